// File: rtl/reaction_timer_core.sv
// Reaction-timer engine: LFSR-randomised wait, GO indicator, packed-BCD reaction count,
// false-start and overflow detection. Define REACTION_BEST_EN to build the best-time register.
module reaction_timer_core #(
    parameter int TICK_DIV   = 50000,
    parameter int DIGITS     = 4,
    parameter int MIN_DELAY  = 1000,
    parameter int DELAY_STEP = 16
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  RESET_N,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic                  led_go,
    output logic                  done,
    output logic                  false_start,
    output logic                  timeout,
    output logic [2:0]            state,
    output logic [7:0]            lfsr
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(MIN_DELAY + 255 * DELAY_STEP + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_GO    = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FALSE = 3'd4;

    function automatic logic [BW-1:0] all_nines();
        logic [BW-1:0] v;
        v = {BW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'd9;
        end
        return v;
    endfunction

    // Decimal increment with carry rippling from digit 0 upward.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    localparam logic [BW-1:0] BCD_ZERO   = {BW{1'b0}};
    localparam logic [BW-1:0] BCD_NINES  = all_nines();
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [PW-1:0] presc_r;
    logic [7:0]    lfsr_r;
    logic [CW-1:0] cnt_r;
    logic [BW-1:0] bcd_r;
    logic [2:0]    state_r;
    logic          led_go_r;
    logic          done_r;
    logic          false_r;
    logic          timeout_r;

    logic          tick_s;
    logic          accept_s;
    logic [CW-1:0] cnt_load_s;
    logic [2:0]    state_nx_s;
    logic [CW-1:0] cnt_nx_s;
    logic [BW-1:0] bcd_nx_s;
    logic          timeout_nx_s;

    assign tick_s     = enable & (presc_r == PRESC_LAST);
    assign cnt_load_s = CW'(MIN_DELAY) + CW'(lfsr_r) * CW'(DELAY_STEP);

    // Trial sequencer: next state, countdown and elapsed-count datapath.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        bcd_nx_s     = bcd_r;
        timeout_nx_s = timeout_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_FALSE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_nx_s   = S_WAIT;
                    cnt_nx_s     = cnt_load_s;
                    bcd_nx_s     = BCD_ZERO;
                    timeout_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_nx_s = S_FALSE;
                end else if (tick_s) begin
                    if (cnt_r <= CNT_ONE) begin
                        state_nx_s = S_GO;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            S_GO: begin
                // A tick landing together with stop is deliberately not counted.
                if (stop) begin
                    state_nx_s = S_DONE;
                end else if (tick_s) begin
                    if (bcd_r == BCD_NINES) begin
                        timeout_nx_s = 1'b1;
                        state_nx_s   = S_DONE;
                    end else begin
                        bcd_nx_s = bcd_inc(bcd_r);
                    end
                end else begin
                    bcd_nx_s = bcd_r;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Tick prescaler (restarted by every accepted start) and free-running LFSR.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_r <= PRESC_ZERO;
            lfsr_r  <= 8'h01;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            if (accept_s || tick_s) begin
                presc_r <= PRESC_ZERO;
            end else if (enable) begin
                presc_r <= presc_r + PRESC_ONE;
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    // State, datapath and per-state status flags, all registered.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            bcd_r     <= BCD_ZERO;
            timeout_r <= 1'b0;
            led_go_r  <= 1'b0;
            done_r    <= 1'b0;
            false_r   <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            bcd_r     <= bcd_nx_s;
            timeout_r <= timeout_nx_s;
            led_go_r  <= (state_nx_s == S_GO);
            done_r    <= (state_nx_s == S_DONE);
            false_r   <= (state_nx_s == S_FALSE);
        end
    end

`ifdef REACTION_BEST_EN
    logic [BW-1:0] best_r;
    logic          best_pend_r;

    // Best-time capture one cycle after a stop-terminated GO; packed BCD orders like binary.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            best_r      <= BCD_NINES;
            best_pend_r <= 1'b0;
        end else begin
            best_pend_r <= (state_r == S_GO) & stop;
            if (best_pend_r && (bcd_r < best_r)) begin
                best_r <= bcd_r;
            end else begin
                best_r <= best_r;
            end
        end
    end

    assign best_bcd = best_r;
`else
    assign best_bcd = {BW{1'b1}};
`endif

    assign bcd         = bcd_r;
    assign led_go      = led_go_r;
    assign done        = done_r;
    assign false_start = false_r;
    assign timeout     = timeout_r;
    assign state       = state_r;
    assign lfsr        = lfsr_r;

endmodule
